// File: rtl/dpram_param.sv
// dpram_param: parametrised true dual-port synchronous RAM shared by two masters.
// Each port has an access enable and byte-enable writes. Same-port read-during-write
// behaviour is selectable, and an optional output register can be added. Same-address
// write collisions are resolved per byte and reported. A sequential engine zero-fills
// the array. The storage array itself is never touched by reset.
module dpram_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int RDW_MODE  = 0,
    parameter int OUT_REG   = 0,
    parameter int COLL_PRIO = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [DATA_W/8-1:0]   be1,
    input  logic [DATA_W/8-1:0]   be2,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [ADDR_W-1:0]     addr2,
    input  logic [DATA_W-1:0]     din1,
    input  logic [DATA_W-1:0]     din2,
    output logic [DATA_W-1:0]     dout1,
    output logic [DATA_W-1:0]     dout2,
    output logic                  dvalid1,
    output logic                  dvalid2,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  collision,
    output logic [7:0]            coll_count
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Overlay the enabled bytes of wdata onto base.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] wdata,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                res[8*i +: 8] = base[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    clr_state_t        state_r;
    clr_state_t        state_next_s;
    logic [ADDR_W-1:0] clr_ctr_r;
    logic [ADDR_W-1:0] clr_ctr_next_s;
    logic              busy_r;
    logic              busy_next_s;

    logic              acc1_s;
    logic              acc2_s;
    logic              wr1_s;
    logic              wr2_s;
    logic              same_addr_s;
    logic              coll_hit_s;
    logic [DATA_W-1:0] old1_s;
    logic [DATA_W-1:0] old2_s;
    logic [DATA_W-1:0] new1_s;
    logic [DATA_W-1:0] new2_s;
    logic [DATA_W-1:0] coll_word_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    logic              collision_r;
    logic [7:0]        coll_count_r;

    // The clear engine owns the array while busy, so port accesses are suppressed.
    assign acc1_s      = en1 & ~busy_r;
    assign acc2_s      = en2 & ~busy_r;
    assign wr1_s       = acc1_s & we1;
    assign wr2_s       = acc2_s & we2;
    assign same_addr_s = wr1_s & wr2_s & (addr1 == addr2);
    assign coll_hit_s  = same_addr_s & (|(be1 & be2));

    assign old1_s = mem_r[addr1];
    assign old2_s = mem_r[addr2];

    // Per-port merged words plus the collision word (loser applied first, winner on top).
    always_comb begin
        new1_s = merge_bytes(old1_s, din1, be1);
        new2_s = merge_bytes(old2_s, din2, be2);
        if (COLL_PRIO != 0) begin
            coll_word_s = merge_bytes(new1_s, din2, be2);
        end else begin
            coll_word_s = merge_bytes(new2_s, din1, be1);
        end
    end

    // Read data per port: pre-write word unless write-first mode on the writing port.
    always_comb begin
        rd1_s = old1_s;
        rd2_s = old2_s;
        if (RDW_MODE != 0) begin
            if (wr1_s) begin
                rd1_s = same_addr_s ? coll_word_s : new1_s;
            end else begin
                rd1_s = old1_s;
            end
            if (wr2_s) begin
                rd2_s = same_addr_s ? coll_word_s : new2_s;
            end else begin
                rd2_s = old2_s;
            end
        end else begin
            rd1_s = old1_s;
            rd2_s = old2_s;
        end
    end

    // Storage array: clear-engine zero fill, or port writes (merged when addresses collide).
    always_ff @(posedge clock) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_ctr_r] <= {DATA_W{1'b0}};
        end else if (same_addr_s) begin
            mem_r[addr1] <= coll_word_s;
        end else begin
            if (wr1_s) begin
                mem_r[addr1] <= new1_s;
            end
            if (wr2_s) begin
                mem_r[addr2] <= new2_s;
            end
        end
    end

    // Clear engine next-state: walk every address once, then return to idle.
    always_comb begin
        state_next_s   = state_r;
        clr_ctr_next_s = clr_ctr_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    state_next_s   = ST_CLEAR;
                    clr_ctr_next_s = {ADDR_W{1'b0}};
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_ctr_r == CTR_LAST) begin
                    state_next_s   = ST_IDLE;
                    clr_ctr_next_s = {ADDR_W{1'b0}};
                end else begin
                    clr_ctr_next_s = clr_ctr_r + ADDR_W'(1);
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clr_ctr_next_s = {ADDR_W{1'b0}};
            end
        endcase
        busy_next_s = (state_next_s == ST_CLEAR);
    end

    // Clear engine state, address counter and registered busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            clr_ctr_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            clr_ctr_r <= clr_ctr_next_s;
            busy_r    <= busy_next_s;
        end
    end

    // Collision pulse and saturating collision counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            collision_r  <= 1'b0;
            coll_count_r <= 8'd0;
        end else begin
            collision_r <= coll_hit_s;
            if (coll_hit_s && (coll_count_r != 8'hFF)) begin
                coll_count_r <= coll_count_r + 8'd1;
            end else begin
                coll_count_r <= coll_count_r;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] stg1_r;
            logic [DATA_W-1:0] stg2_r;
            logic              stg_v1_r;
            logic              stg_v2_r;

            // Two-stage read return: capture stage, then output register.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    stg1_r   <= {DATA_W{1'b0}};
                    stg2_r   <= {DATA_W{1'b0}};
                    stg_v1_r <= 1'b0;
                    stg_v2_r <= 1'b0;
                    dout1    <= {DATA_W{1'b0}};
                    dout2    <= {DATA_W{1'b0}};
                    dvalid1  <= 1'b0;
                    dvalid2  <= 1'b0;
                end else begin
                    stg_v1_r <= acc1_s;
                    stg_v2_r <= acc2_s;
                    if (acc1_s) begin
                        stg1_r <= rd1_s;
                    end
                    if (acc2_s) begin
                        stg2_r <= rd2_s;
                    end
                    dvalid1 <= stg_v1_r;
                    dvalid2 <= stg_v2_r;
                    if (stg_v1_r) begin
                        dout1 <= stg1_r;
                    end
                    if (stg_v2_r) begin
                        dout2 <= stg2_r;
                    end
                end
            end
        end else begin : g_no_out_reg
            // Single-stage read return; dout holds between accesses.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    dout1   <= {DATA_W{1'b0}};
                    dout2   <= {DATA_W{1'b0}};
                    dvalid1 <= 1'b0;
                    dvalid2 <= 1'b0;
                end else begin
                    dvalid1 <= acc1_s;
                    dvalid2 <= acc2_s;
                    if (acc1_s) begin
                        dout1 <= rd1_s;
                    end
                    if (acc2_s) begin
                        dout2 <= rd2_s;
                    end
                end
            end
        end
    endgenerate

    assign busy       = busy_r;
    assign collision  = collision_r;
    assign coll_count = coll_count_r;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances share the stimulus. Instance A uses the default
// parameters. Instance B uses write-first, an output register and port-2 collision priority.
// A behavioural model (array memory, ordered byte writes, a delay line per port) predicts
// every output, cycle by cycle.
module tb_dpram_param;

    logic        clock;
    logic        reset;
    logic        en1, en2, we1, we2, clear_start;
    logic [3:0]  be1, be2;
    logic [2:0]  addr1, addr2;
    logic [31:0] din1, din2;

    logic [1:0][1:0][31:0] dout_w;
    logic [1:0][1:0]       dval_w;
    logic [1:0]            busy_w;
    logic [1:0]            coll_w;
    logic [1:0][7:0]       cnt_w;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] mem_m [2][8];
    logic        busy_m;
    int          ctr_m;
    logic        coll_m;
    int          cnt_m;
    logic [31:0] exp_d [2][2];
    logic        exp_v [2][2];
    logic [31:0] stg_d [2];
    logic        stg_v [2];

    dpram_param u_dut_a (
        .clock(clock), .reset(reset),
        .en1(en1), .en2(en2), .we1(we1), .we2(we2),
        .be1(be1), .be2(be2), .addr1(addr1), .addr2(addr2),
        .din1(din1), .din2(din2),
        .dout1(dout_w[0][0]), .dout2(dout_w[0][1]),
        .dvalid1(dval_w[0][0]), .dvalid2(dval_w[0][1]),
        .clear_start(clear_start), .busy(busy_w[0]),
        .collision(coll_w[0]), .coll_count(cnt_w[0])
    );

    dpram_param #(.RDW_MODE(1), .OUT_REG(1), .COLL_PRIO(1)) u_dut_b (
        .clock(clock), .reset(reset),
        .en1(en1), .en2(en2), .we1(we1), .we2(we2),
        .be1(be1), .be2(be2), .addr1(addr1), .addr2(addr2),
        .din1(din1), .din2(din2),
        .dout1(dout_w[1][0]), .dout2(dout_w[1][1]),
        .dvalid1(dval_w[1][0]), .dvalid2(dval_w[1][1]),
        .clear_start(clear_start), .busy(busy_w[1]),
        .collision(coll_w[1]), .coll_count(cnt_w[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        en1 = 1'b0; en2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        be1 = 4'h0; be2 = 4'h0; addr1 = 3'd0; addr2 = 3'd0;
        din1 = 32'd0; din2 = 32'd0; clear_start = 1'b0;
    endtask

    task automatic model_reset();
        busy_m = 1'b0; ctr_m = 0; coll_m = 1'b0; cnt_m = 0;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                exp_d[c][p] = 32'd0;
                exp_v[c][p] = 1'b0;
            end
            stg_d[c] = 32'd0;
            stg_v[c] = 1'b0;
        end
    endtask

    task automatic apply_write(input int c, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_m[c][a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // One clock: predict from current inputs, advance the clock, compare every output.
    task automatic tick();
        logic        acc [2];
        logic        wr [2];
        logic [2:0]  a [2];
        logic [31:0] ret [2][2];
        logic [31:0] snap [8];
        acc[0] = en1 && !busy_m;
        acc[1] = en2 && !busy_m;
        wr[0]  = acc[0] && we1;
        wr[1]  = acc[1] && we2;
        a[0] = addr1;
        a[1] = addr2;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) snap[k] = mem_m[c][k];
            // loser writes first, winner overwrites shared bytes
            if (c == 0) begin
                if (wr[1]) apply_write(c, addr2, din2, be2);
                if (wr[0]) apply_write(c, addr1, din1, be1);
            end else begin
                if (wr[0]) apply_write(c, addr1, din1, be1);
                if (wr[1]) apply_write(c, addr2, din2, be2);
            end
            for (int p = 0; p < 2; p++) begin
                ret[c][p] = (wr[p] && c == 1) ? mem_m[c][a[p]] : snap[a[p]];
            end
        end
        if (busy_m) begin
            mem_m[0][ctr_m] = 32'd0;
            mem_m[1][ctr_m] = 32'd0;
            ctr_m = ctr_m + 1;
            if (ctr_m == 8) busy_m = 1'b0;
        end else if (clear_start) begin
            busy_m = 1'b1;
            ctr_m  = 0;
        end
        coll_m = wr[0] && wr[1] && (addr1 == addr2) && ((be1 & be2) != 4'h0);
        if (coll_m && cnt_m < 255) cnt_m = cnt_m + 1;
        for (int p = 0; p < 2; p++) begin
            exp_v[0][p] = acc[p];
            if (acc[p]) exp_d[0][p] = ret[0][p];
            exp_v[1][p] = stg_v[p];
            if (stg_v[p]) exp_d[1][p] = stg_d[p];
            stg_v[p] = acc[p];
            if (acc[p]) stg_d[p] = ret[1][p];
        end
        @(posedge clock);
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (dval_w[c][p] !== exp_v[c][p]) begin
                    failures++;
                    $display("FAIL dvalid cfg%0d port%0d: got %b want %b at %0t", c, p + 1, dval_w[c][p], exp_v[c][p], $time);
                end
                checks++;
                if (dout_w[c][p] !== exp_d[c][p]) begin
                    failures++;
                    $display("FAIL dout cfg%0d port%0d: got %h want %h at %0t", c, p + 1, dout_w[c][p], exp_d[c][p], $time);
                end
            end
            checks++;
            if (busy_w[c] !== busy_m) begin
                failures++;
                $display("FAIL busy cfg%0d: got %b want %b at %0t", c, busy_w[c], busy_m, $time);
            end
            checks++;
            if (coll_w[c] !== coll_m) begin
                failures++;
                $display("FAIL collision cfg%0d: got %b want %b at %0t", c, coll_w[c], coll_m, $time);
            end
            checks++;
            if (cnt_w[c] !== 8'(cnt_m)) begin
                failures++;
                $display("FAIL coll_count cfg%0d: got %0d want %0d at %0t", c, cnt_w[c], cnt_m, $time);
            end
        end
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            en1 = 1'($urandom); en2 = 1'($urandom); we1 = 1'($urandom); we2 = 1'($urandom);
            be1 = 4'($urandom); be2 = 4'($urandom); addr1 = 3'($urandom); addr2 = 3'($urandom);
            din1 = $urandom; din2 = $urandom; clear_start = 1'($urandom);
            @(posedge clock);
            #1;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (dout_w[c] !== 64'd0 || dval_w[c] !== 2'b00 || busy_w[c] !== 1'b0 ||
                    coll_w[c] !== 1'b0 || cnt_w[c] !== 8'd0) begin
                    failures++;
                    $display("FAIL reset_state cfg%0d: got dout=%h dv=%b busy=%b coll=%b cnt=%0d want all 0",
                             c, dout_w[c], dval_w[c], busy_w[c], coll_w[c], cnt_w[c]);
                end
            end
        end
        idle();
        reset = 1'b1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        k = 0;
        while (busy_w[0] === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (busy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL init_clear_timeout: busy got %b want 0", busy_w[0]);
        end
        en1 = 1'b1; addr1 = 3'd5;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'd0 || dval_w[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL init_read5: got dout=%h dv=%b want 0 / 1", dout_w[0][0], dval_w[0][0]);
        end
        tick();
    endtask

    task automatic test_cross_port_read();
        en2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 3'd7; din2 = 32'd88;
        tick();
        idle();
        en1 = 1'b1; addr1 = 3'd7;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'd88 || dval_w[0][0] !== 1'b1 || dval_w[1][0] !== 1'b0) begin
            failures++;
            $display("FAIL read7_lat1: got a=%h dv_a=%b dv_b=%b want 88/1/0", dout_w[0][0], dval_w[0][0], dval_w[1][0]);
        end
        tick();
        checks++;
        if (dout_w[1][0] !== 32'd88 || dval_w[1][0] !== 1'b1) begin
            failures++;
            $display("FAIL read7_lat2: got b=%h dv_b=%b want 88/1", dout_w[1][0], dval_w[1][0]);
        end
    endtask

    task automatic test_byte_enable();
        en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'd3; din1 = 32'hAABBCCDD;
        tick();
        be1 = 4'b0010; din1 = 32'h11111111;
        tick();
        we1 = 1'b0; be1 = 4'h0;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'hAABB11DD) begin
            failures++;
            $display("FAIL byte_merge_a: got %h want AABB11DD", dout_w[0][0]);
        end
        tick();
        checks++;
        if (dout_w[1][0] !== 32'hAABB11DD) begin
            failures++;
            $display("FAIL byte_merge_b: got %h want AABB11DD", dout_w[1][0]);
        end
    endtask

    task automatic test_collision();
        en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'd4; din1 = 32'd13;
        en2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 3'd4; din2 = 32'd96;
        tick();
        idle();
        checks++;
        if (coll_w !== 2'b11 || cnt_w[0] !== 8'd1 || cnt_w[1] !== 8'd1) begin
            failures++;
            $display("FAIL coll_pulse: got coll=%b cnt=%0d/%0d want 11, 1/1", coll_w, cnt_w[0], cnt_w[1]);
        end
        en1 = 1'b1; addr1 = 3'd4;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'd13 || coll_w !== 2'b00) begin
            failures++;
            $display("FAIL coll_prio1: got %h coll=%b want 13, 00", dout_w[0][0], coll_w);
        end
        tick();
        checks++;
        if (dout_w[1][0] !== 32'd96) begin
            failures++;
            $display("FAIL coll_prio2: got %h want 96", dout_w[1][0]);
        end
        en1 = 1'b1; we1 = 1'b1; be1 = 4'h3; addr1 = 3'd4; din1 = 32'hAAAAAAAA;
        en2 = 1'b1; we2 = 1'b1; be2 = 4'hC; addr2 = 3'd4; din2 = 32'h55555555;
        tick();
        idle();
        checks++;
        if (coll_w !== 2'b00 || cnt_w[0] !== 8'd1) begin
            failures++;
            $display("FAIL split_be_no_coll: got coll=%b cnt=%0d want 00, 1", coll_w, cnt_w[0]);
        end
        en1 = 1'b1; addr1 = 3'd4;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'h5555AAAA) begin
            failures++;
            $display("FAIL split_be_merge: got %h want 5555AAAA", dout_w[0][0]);
        end
        tick();
    endtask

    task automatic test_rdw();
        en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'd6; din1 = 32'd5;
        tick();
        din1 = 32'd99;
        en2 = 1'b1; addr2 = 3'd6;
        tick();
        idle();
        checks++;
        if (dout_w[0][0] !== 32'd5 || dout_w[0][1] !== 32'd5) begin
            failures++;
            $display("FAIL rdw_read_first: got p1=%h p2=%h want 5/5", dout_w[0][0], dout_w[0][1]);
        end
        tick();
        checks++;
        if (dout_w[1][0] !== 32'd99 || dout_w[1][1] !== 32'd5) begin
            failures++;
            $display("FAIL rdw_write_first: got p1=%h p2=%h want 99/5", dout_w[1][0], dout_w[1][1]);
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i += 2) begin
            en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'(i);     din1 = 32'hC0DE0000 + 32'(i) + 32'd1;
            en2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 3'(i + 1); din2 = 32'hC0DE0000 + 32'(i) + 32'd2;
            tick();
        end
        idle();
    endtask

    task automatic read_all_check(input logic [7:0] zero_mask);
        logic [31:0] want;
        for (int i = 0; i < 8; i++) begin
            en1 = 1'b1; addr1 = 3'(i);
            tick();
            idle();
            want = zero_mask[i] ? 32'd0 : (32'hC0DE0000 + 32'(i) + 32'd1);
            checks++;
            if (dout_w[0][0] !== want) begin
                failures++;
                $display("FAIL clear_readback addr%0d: got %h want %h", i, dout_w[0][0], want);
            end
        end
        tick();
    endtask

    task automatic test_clear();
        int busy_cnt;
        int k;
        fill_all();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        busy_cnt = 0;
        k = 0;
        while (busy_w[0] === 1'b1 && k < 20) begin
            busy_cnt++;
            en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'($urandom); din1 = $urandom;
            en2 = 1'b1; addr2 = 3'($urandom); clear_start = 1'($urandom);
            tick();
            k++;
        end
        idle();
        checks++;
        if (busy_cnt != 8) begin
            failures++;
            $display("FAIL busy_length: got %0d want 8", busy_cnt);
        end
        read_all_check(8'hFF);

        fill_all();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy_w !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_clear_busy: got %b want 00", busy_w);
        end
        #3;
        reset = 1'b1;
        read_all_check(8'h07);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en1 = 1'($urandom); en2 = 1'($urandom); we1 = 1'($urandom); we2 = 1'($urandom);
            be1 = 4'($urandom); be2 = 4'($urandom);
            addr1 = 3'($urandom_range(0, 3)); addr2 = 3'($urandom_range(0, 3));
            din1 = $urandom; din2 = $urandom;
            clear_start = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        repeat (12) tick();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            en1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 3'(n); din1 = $urandom;
            en2 = 1'b1; we2 = 1'b1; be2 = 4'h1; addr2 = 3'(n); din2 = $urandom;
            tick();
        end
        idle();
        tick();
        checks++;
        if (cnt_w[0] !== 8'd255 || cnt_w[1] !== 8'd255) begin
            failures++;
            $display("FAIL coll_saturate: got %0d/%0d want 255", cnt_w[0], cnt_w[1]);
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) mem_m[c][k] = 32'd0;
        end
        #2;
        test_reset();
        test_cross_port_read();
        test_byte_enable();
        test_collision();
        test_rdw();
        test_clear();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
